// File: rtl/io_sequencer_if.sv
// ---------------------------------------------------------------------------
// io_sequencer_if
//   Bundle of everything that passes between the I/O sequencer and the
//   blocks around it: the control unit (requests, stall, done), the board
//   debouncers (switch, enter), the register-file write-data mux (in_data)
//   and the BCD/7-segment path (disp_value, disp_write).
//
//   master : control unit / board side. Drives the requests, out_data,
//            switch and enter; receives the sequencer outputs.
//   slave  : io_sequencer side.
// ---------------------------------------------------------------------------
interface io_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int IN_W   = 16
);
    logic              in_req;
    logic              out_req;
    logic [DATA_W-1:0] out_data;
    logic [IN_W-1:0]   switch;
    logic              enter;
    logic              stall;
    logic              done;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] disp_value;
    logic              disp_write;
    logic              busy;

    modport master (
        output in_req, out_req, out_data, switch, enter,
        input  stall, done, in_data, disp_value, disp_write, busy
    );

    modport slave (
        input  in_req, out_req, out_data, switch, enter,
        output stall, done, in_data, disp_value, disp_write, busy
    );
endinterface

// File: rtl/io_sequencer.sv
// ---------------------------------------------------------------------------
// io_sequencer
//   Multicycle IN/OUT controller. An OUT latches out_data into the display
//   register and holds the control unit stalled for HOLD_CYCLES cycles. An
//   IN stalls until a debounced enter press, then captures the switches.
//   Each operation ends with a one-cycle done pulse during which stall is
//   low, so the control unit advances on the done cycle.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-low
//     bus    io_sequencer_if.slave:
//              in_req, out_req, out_data, switch, enter  (inputs)
//              stall, done, in_data, disp_value, disp_write, busy (outputs)
// ---------------------------------------------------------------------------
module io_sequencer #(
    parameter int DATA_W      = 32,
    parameter int IN_W        = 16,
    parameter int HOLD_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    io_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_IN,
        OUT_HOLD,
        DONE
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t            state;
    state_t            nextState;
    logic [7:0]        cnt;
    logic              enterQ;
    logic              enterRise;
    logic [DATA_W-1:0] inDataReg;
    logic [DATA_W-1:0] dispValueReg;

    assign enterRise = bus.enter & ~enterQ;

    // enterQ resets high so a button held through reset is not a press.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            enterQ       <= 1'b1;
            inDataReg    <= '0;
            dispValueReg <= '0;
        end else begin
            state  <= nextState;
            enterQ <= bus.enter;
            if (state == IDLE && bus.out_req) begin
                dispValueReg <= bus.out_data;
                cnt          <= HOLD_LAST;
            end else if (state == OUT_HOLD && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (state == WAIT_IN && enterRise) begin
                inDataReg <= DATA_W'(bus.switch);
            end
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                // OUT wins a tie; a still-pending in_req is served afterwards.
                if (bus.out_req) begin
                    nextState = OUT_HOLD;
                end else if (bus.in_req) begin
                    nextState = WAIT_IN;
                end
            end
            WAIT_IN: begin
                if (enterRise) begin
                    nextState = DONE;
                end
            end
            OUT_HOLD: begin
                if (cnt == 8'd0) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // The counter is loaded with HOLD_LAST on entry and decrements every
    // cycle, so it still equals HOLD_LAST only in the first OUT_HOLD cycle.
    assign bus.disp_write = (state == OUT_HOLD) && (cnt == HOLD_LAST);
    assign bus.done       = (state == DONE);
    assign bus.busy       = (state != IDLE);
    assign bus.stall      = ((state == IDLE) && (bus.in_req || bus.out_req))
                          || (state == WAIT_IN)
                          || (state == OUT_HOLD);
    assign bus.in_data    = inDataReg;
    assign bus.disp_value = dispValueReg;

endmodule

// File: tb/tb_io_sequencer.sv
// ---------------------------------------------------------------------------
// tb_io_sequencer
//   Directed scenarios followed by random traffic. Expected outputs come from
//   a transaction-timing model: each accepted operation is tracked by its
//   kind and its cycle number since the request cycle, and the outputs are
//   derived from the documented timing (OUT done at cycle HOLD+1, IN done
//   the cycle after the press, etc.).
// ---------------------------------------------------------------------------
module tb_io_sequencer;

    localparam int DATA_W = 32;
    localparam int IN_W   = 16;
    localparam int HOLD   = 4;

    logic clk;
    logic reset;

    io_sequencer_if #(.DATA_W(DATA_W), .IN_W(IN_W)) bus ();

    io_sequencer #(
        .DATA_W(DATA_W),
        .IN_W(IN_W),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;
    int cycleNo     = 0;
    int doneSeen    = 0;

    // Model: kind 0 = no operation, 1 = IN, 2 = OUT. age = cycles since the
    // request cycle. doneAt = age at which an IN completes (-1 = no press yet).
    int          mKind   = 0;
    int          mAge    = 0;
    int          mDoneAt = -1;
    bit          mPrevEnter = 1'b1;
    logic [31:0] expIn   = '0;
    logic [31:0] expDisp = '0;

    task automatic checkVal(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycleNo, got, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model, step past edge.
    task automatic cycle();
        bit eStall, eDone, eDw, eBusy, rise;
        @(negedge clk);
        eStall = 0; eDone = 0; eDw = 0; eBusy = 0;
        if (mKind == 0) begin
            eStall = bus.in_req | bus.out_req;
        end else if (mKind == 2) begin
            eBusy = 1;
            if (mAge == HOLD + 1) eDone = 1;
            else begin
                eStall = 1;
                eDw    = (mAge == 1);
            end
        end else begin
            eBusy = 1;
            if (mDoneAt == mAge) eDone = 1;
            else eStall = 1;
        end
        checkVal("stall", 32'(bus.stall), 32'(eStall));
        checkVal("done", 32'(bus.done), 32'(eDone));
        checkVal("disp_write", 32'(bus.disp_write), 32'(eDw));
        checkVal("busy", 32'(bus.busy), 32'(eBusy));
        checkVal("in_data", bus.in_data, expIn);
        checkVal("disp_value", bus.disp_value, expDisp);
        if (bus.done) doneSeen++;

        if (!reset) begin
            mKind = 0; mAge = 0; mDoneAt = -1;
            expIn = '0; expDisp = '0;
            mPrevEnter = 1'b1;
        end else begin
            rise = bus.enter && !mPrevEnter;
            mPrevEnter = bus.enter;
            if (mKind == 0) begin
                if (bus.out_req) begin
                    mKind = 2; mAge = 1; expDisp = bus.out_data;
                end else if (bus.in_req) begin
                    mKind = 1; mAge = 1; mDoneAt = -1;
                end
            end else if (eDone) begin
                mKind = 0; mAge = 0; mDoneAt = -1;
            end else begin
                if (mKind == 1 && mDoneAt < 0 && rise) begin
                    mDoneAt = mAge + 1;
                    expIn   = 32'(bus.switch);
                end
                mAge++;
            end
        end
        @(posedge clk);
        #1;
        cycleNo++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset = 1'b0;
        bus.in_req = 0; bus.out_req = 0; bus.out_data = '0;
        bus.switch = '0; bus.enter = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run(2);

        // OUT of 123
        bus.enter = 1'b0;
        bus.out_req = 1; bus.out_data = 32'd123;
        doneSeen = 0;
        run(6);
        checkVal("out_done_count", 32'(doneSeen), 32'd1);
        bus.out_req = 0;
        run(2);

        // IN of 0x8001, press in cycle 7, then enter held high
        bus.in_req = 1; bus.switch = 16'h8001;
        run(7);
        bus.enter = 1;
        run(2);
        bus.in_req = 0;
        run(3);
        checkVal("in_capture", bus.in_data, 32'h0000_8001);

        // Simultaneous requests: OUT first, then IN
        bus.enter = 0;
        bus.in_req = 1; bus.out_req = 1; bus.out_data = 32'd42;
        run(6);
        bus.out_req = 0;
        bus.switch = 16'd7;
        run(3);
        bus.enter = 1;
        run(2);
        bus.in_req = 0; bus.enter = 0;
        run(2);
        checkVal("simul_in", bus.in_data, 32'd7);
        checkVal("simul_disp", bus.disp_value, 32'd42);

        // Stray presses in IDLE, then IN without a press
        bus.enter = 1; run(1);
        bus.enter = 0; run(1);
        bus.enter = 1; run(1);
        bus.enter = 0;
        bus.in_req = 1;
        doneSeen = 0;
        run(50);
        checkVal("stray_no_done", 32'(doneSeen), 32'd0);

        // Reset during WAIT_IN
        reset = 0; run(1);
        reset = 1; bus.in_req = 0;
        doneSeen = 0;
        run(2);
        checkVal("rst_in_no_done", 32'(doneSeen), 32'd0);

        // Reset at OUT_HOLD cycle 2
        bus.out_req = 1; bus.out_data = 32'd99;
        run(3);
        reset = 0; run(1);
        reset = 1; bus.out_req = 0;
        doneSeen = 0;
        run(2);
        checkVal("rst_out_no_done", 32'(doneSeen), 32'd0);
        checkVal("rst_out_disp", bus.disp_value, 32'd0);

        // Back-to-back OUTs
        bus.out_req = 1; bus.out_data = 32'd5;
        doneSeen = 0;
        run(6);
        bus.out_data = 32'd6;
        run(6);
        bus.out_req = 0;
        run(2);
        checkVal("b2b_done_count", 32'(doneSeen), 32'd2);
        checkVal("b2b_disp", bus.disp_value, 32'd6);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 99) != 0);
            bus.in_req   = ($urandom_range(0, 2) == 0);
            bus.out_req  = ($urandom_range(0, 4) == 0);
            bus.out_data = $urandom;
            bus.switch   = 16'($urandom);
            if ($urandom_range(0, 3) == 0) bus.enter = ~bus.enter;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/io_sequencer.md
# io_sequencer

Multicycle I/O controller that sequences the processor's IN (read switches) and OUT (write 7-segment display) operations between the control unit and the board peripherals. While an operation is in progress it stalls the control unit. For IN it waits for a debounced enter press and captures the switch value. For OUT it latches the result into the display register and holds for a fixed number of cycles. It sits between the control unit, the switch/enter debouncers, the register-file write-data mux and the BCD/7-segment path.

## Interface
Parameters:
- DATA_W, 32, width of the datapath words (out_data, in_data, disp_value).
- IN_W, 16, width of the switch input; must be <= DATA_W.
- HOLD_CYCLES, 4, number of cycles an OUT operation holds the stall; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_req  in  1  IN request from the control unit; level, held until done.
- out_req  in  1  OUT request from the control unit; level, held until done.
- out_data  in  DATA_W  value to display (the ALU-out register).
- switch  in  IN_W  board switches.
- enter  in  1  debounced enter button, level.
- stall  out  1  freezes the control unit while an operation is pending.
- done  out  1  one-cycle completion pulse.
- in_data  out  DATA_W  captured switch value, zero-extended; feeds the register-file write-data mux.
- disp_value  out  DATA_W  display register; feeds binToBCD.
- disp_write  out  1  one-cycle pulse when disp_value changes.
- busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, WAIT_IN, OUT_HOLD, DONE. Encoding is free.
- Edge detect: enter_q <= enter each cycle; enter_rise = enter & ~enter_q. enter_q resets to 1, so a button held through reset never counts as a press.
- IDLE:
  - out_req=1 -> OUT_HOLD. At the same edge: disp_value <= out_data, cnt <= HOLD_CYCLES-1.
  - else in_req=1 -> WAIT_IN.
  - out_req has priority when both requests are high. in_req stays asserted and is served after the OUT completes.
  - enter_rise in IDLE is ignored; stray presses are discarded, never queued.
- WAIT_IN: on enter_rise, in_data <= {zeros, switch} and go to DONE. Otherwise stay; there is no timeout.
- OUT_HOLD: disp_write=1 in the first OUT_HOLD cycle only. cnt decrements each cycle. At cnt==0 -> DONE.
- DONE: done=1 for one cycle, then -> IDLE unconditionally. Requests sampled during DONE are ignored. The requester must drop its request in the cycle after done; a request still high in IDLE is a new operation.
- stall (combinational) = (state==IDLE & (in_req|out_req)) | state==WAIT_IN | state==OUT_HOLD. stall is 0 in DONE so the control unit advances on the done cycle.
- in_data and disp_value hold their values until the next capture of the same kind.
- Reset values: state=IDLE, in_data=0, disp_value=0, cnt=0, enter_q=1, stall=0 (unless a request is high), done=0, disp_write=0, busy=0.
- Reset asserted mid-operation: next edge forces IDLE and clears in_data and disp_value. No done pulse is produced for the aborted operation.

## Timing
- Cycle 0 is the IDLE cycle with the request high. stall is already 1 in cycle 0, with no lost cycle.
- OUT:
  - disp_value is valid and disp_write=1 in cycle 1.
  - OUT_HOLD occupies cycles 1..HOLD_CYCLES.
  - done=1 in cycle HOLD_CYCLES+1.
  - Total stall = HOLD_CYCLES+1 cycles.
- IN:
  - WAIT_IN starts in cycle 1.
  - enter_rise in cycle k (k>=1) -> in_data valid and done=1 in cycle k+1.
  - Minimum stall is 2 cycles.
- in_data and disp_value are registered outputs; done, disp_write, stall and busy are glitch-free decodes of registered state plus requests.

## Test plan
- Reset, then OUT: hold reset low 2 cycles with enter=1, release. Expect all outputs 0 and disp_value=0. out_req=1 with out_data=123, HOLD_CYCLES=4 -> stall high cycles 0..4, disp_write only in cycle 1, disp_value=123 from cycle 1, done in cycle 5.
- IN: in_req=1, switch=0x8001, enter rises in cycle 7 -> stall high cycles 0..7, in_data=0x00008001 and done in cycle 8. enter held high afterwards produces no second capture.
- Simultaneous requests: in_req=out_req=1 with out_data=42 -> OUT first (done in cycle 5), drop out_req. In the following IDLE cycle the IN starts; press enter with switch=7 -> in_data=7.
- Stray press: enter pulses in IDLE with no request, then in_req=1 without a press -> stall remains high and done is never asserted over 50 cycles.
- Mid-op reset: reset low during WAIT_IN and, separately, at OUT_HOLD cycle 2 -> next cycle IDLE, disp_value=0, in_data=0, no done pulse.
- Back-to-back: out_req reasserted in the cycle after done -> new OUT accepted immediately, disp_write pulses again, total stall HOLD_CYCLES+1.
